// File: rtl/net_cmd_unit.sv
// Network command unit: filters packets addressed to this core, queues imem/reg-file writes,
// issues the start-PC pulse and tracks the IDLE/RUN/ERR run state plus the barrier registers.
module net_cmd_unit #(
  parameter int unsigned      ID_W     = 10,
  parameter logic [ID_W-1:0]  NET_ID   = ID_W'(1),
  parameter bit               BCAST_EN = 1'b1,
  parameter int unsigned      ADDR_W   = 10,
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      MASK_W   = 3,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      net_valid_i,
  input  logic [ID_W-1:0]           net_id_i,
  input  logic [2:0]                net_op_i,
  input  logic [ADDR_W-1:0]         net_addr_i,
  input  logic [DATA_W-1:0]         net_data_i,
  output logic                      net_ready_o,
  output logic                      wr_valid_o,
  output logic                      wr_is_instr_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [DATA_W-1:0]         wr_data_o,
  input  logic                      wr_ready_i,
  output logic                      pc_wr_valid_o,
  output logic [ADDR_W-1:0]         pc_wr_addr_o,
  input  logic                      halt_i,
  input  logic                      bar_commit_i,
  input  logic [MASK_W-1:0]         bar_val_i,
  output logic [MASK_W-1:0]         barrier_o,
  output logic [1:0]                state_o,
  output logic                      exception_o,
  output logic [$clog2(DEPTH):0]    fifo_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

  localparam logic [2:0] OpInstr = 3'd1;
  localparam logic [2:0] OpReg   = 3'd2;
  localparam logic [2:0] OpPc    = 3'd3;
  localparam logic [2:0] OpBar   = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StErr  = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;

  logic [EntW-1:0]   r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;
  logic              r_pc_valid;
  logic [ADDR_W-1:0] r_pc_addr;
  logic [MASK_W-1:0] r_mask;
  logic [MASK_W-1:0] r_value;

  logic w_match;
  logic w_is_wr;
  logic w_is_pc;
  logic w_is_bar;
  logic w_empty;
  logic w_full;
  logic w_err;
  logic w_push;
  logic w_pop;
  logic w_pc_acc;
  logic w_pc_err;
  logic w_bar_ld;

  assign w_match  = net_valid_i &
                    ((net_id_i == NET_ID) | (BCAST_EN & (&net_id_i)));
  assign w_is_wr  = (net_op_i == OpInstr) | (net_op_i == OpReg);
  assign w_is_pc  = (net_op_i == OpPc);
  assign w_is_bar = (net_op_i == OpBar);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CntW'(DEPTH));
  assign w_err    = (r_state == StErr);

  assign w_push   = w_match & w_is_wr & ~w_full & ~w_err;
  assign w_pop    = wr_valid_o & wr_ready_i;
  assign w_pc_acc = w_match & w_is_pc & w_empty & (r_state == StIdle);
  // A second start while running is fatal regardless of FIFO occupancy.
  assign w_pc_err = w_match & w_is_pc & (r_state == StRun);
  assign w_bar_ld = w_match & w_is_bar & ~w_err;

  always_comb begin
    net_ready_o = 1'b1;
    if (w_match && !w_err) begin
      if (w_is_wr) begin
        net_ready_o = ~w_full;
      end else if (w_is_pc) begin
        net_ready_o = w_empty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_pc_acc) w_state_nxt = StRun;
      StRun: begin
        if (w_pc_err) begin
          w_state_nxt = StErr;
        end else if (halt_i) begin
          w_state_nxt = StIdle;
        end
      end
      StErr:   w_state_nxt = StErr;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {(net_op_i == OpInstr), net_addr_i, net_data_i};
    end
  end

  // Entering ERR flushes the queue in the same edge so the count reads 0 with state ERR.
  always_ff @(posedge clk) begin
    if (!reset || w_state_nxt == StErr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_valid <= 1'b0;
      r_pc_addr  <= '0;
      r_mask     <= '0;
      r_value    <= '0;
    end else begin
      r_pc_valid <= w_pc_acc;
      if (w_pc_acc) r_pc_addr <= net_addr_i;
      if (w_bar_ld) r_mask <= net_data_i[MASK_W-1:0];
      if (w_pc_acc) begin
        r_value <= net_data_i[MASK_W-1:0];
      end else if (r_state == StRun && bar_commit_i) begin
        r_value <= bar_val_i;
      end
    end
  end

  assign wr_valid_o    = ~w_empty & ~w_err;
  assign {wr_is_instr_o, wr_addr_o, wr_data_o} = r_mem[r_rptr];
  assign pc_wr_valid_o = r_pc_valid;
  assign pc_wr_addr_o  = r_pc_addr;
  assign barrier_o     = r_mask & r_value;
  assign state_o       = r_state;
  assign exception_o   = w_err;
  assign fifo_count_o  = r_count;

endmodule

// File: tb/tb_net_cmd_unit.sv
// Directed bench for net_cmd_unit: write-queue contents checked through a scoreboard queue,
// control/state outputs checked against constants at each step.
module tb_net_cmd_unit;

  localparam logic [2:0] OpNull  = 3'd0;
  localparam logic [2:0] OpInstr = 3'd1;
  localparam logic [2:0] OpReg   = 3'd2;
  localparam logic [2:0] OpPc    = 3'd3;
  localparam logic [2:0] OpBar   = 3'd4;

  typedef logic [42:0] ent_t;

  logic        clk;
  logic        reset;
  logic        net_valid_i;
  logic [9:0]  net_id_i;
  logic [2:0]  net_op_i;
  logic [9:0]  net_addr_i;
  logic [31:0] net_data_i;
  logic        wr_ready_i;
  logic        halt_i;
  logic        bar_commit_i;
  logic [2:0]  bar_val_i;

  logic        net_ready_o, wr_valid_o, wr_is_instr_o, pc_wr_valid_o, exception_o;
  logic [9:0]  wr_addr_o, pc_wr_addr_o;
  logic [31:0] wr_data_o;
  logic [2:0]  barrier_o;
  logic [1:0]  state_o;
  logic [2:0]  fifo_count_o;

  logic        b_net_ready_o, b_wr_valid_o, b_wr_is_instr_o, b_pc_wr_valid_o, b_exception_o;
  logic [9:0]  b_wr_addr_o, b_pc_wr_addr_o;
  logic [31:0] b_wr_data_o;
  logic [2:0]  b_barrier_o;
  logic [1:0]  b_state_o;
  logic [2:0]  b_fifo_count_o;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q[$];

  net_cmd_unit dut (
    .clk(clk), .reset(reset), .net_valid_i(net_valid_i), .net_id_i(net_id_i),
    .net_op_i(net_op_i), .net_addr_i(net_addr_i), .net_data_i(net_data_i),
    .net_ready_o(net_ready_o), .wr_valid_o(wr_valid_o), .wr_is_instr_o(wr_is_instr_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
    .pc_wr_valid_o(pc_wr_valid_o), .pc_wr_addr_o(pc_wr_addr_o), .halt_i(halt_i),
    .bar_commit_i(bar_commit_i), .bar_val_i(bar_val_i), .barrier_o(barrier_o),
    .state_o(state_o), .exception_o(exception_o), .fifo_count_o(fifo_count_o)
  );

  net_cmd_unit #(.BCAST_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .net_valid_i(net_valid_i), .net_id_i(net_id_i),
    .net_op_i(net_op_i), .net_addr_i(net_addr_i), .net_data_i(net_data_i),
    .net_ready_o(b_net_ready_o), .wr_valid_o(b_wr_valid_o), .wr_is_instr_o(b_wr_is_instr_o),
    .wr_addr_o(b_wr_addr_o), .wr_data_o(b_wr_data_o), .wr_ready_i(wr_ready_i),
    .pc_wr_valid_o(b_pc_wr_valid_o), .pc_wr_addr_o(b_pc_wr_addr_o), .halt_i(halt_i),
    .bar_commit_i(bar_commit_i), .bar_val_i(bar_val_i), .barrier_o(b_barrier_o),
    .state_o(b_state_o), .exception_o(b_exception_o), .fifo_count_o(b_fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [9:0] id, input logic [9:0] addr,
                      input logic [31:0] data);
    net_valid_i = 1'b1;
    net_op_i    = op;
    net_id_i    = id;
    net_addr_i  = addr;
    net_data_i  = data;
    #1;
  endtask

  task automatic quiet;
    net_valid_i = 1'b0;
    net_op_i    = OpNull;
    net_id_i    = '0;
    net_addr_i  = '0;
    net_data_i  = '0;
    #1;
  endtask

  // Head must match the oldest expected entry; the pop happens at the following edge.
  task automatic consume(input string tag);
    ent_t exp;
    exp = (q.size() > 0) ? q.pop_front() : '0;
    chk({tag, "_valid"}, wr_valid_o, 1);
    chk({tag, "_head"}, {wr_is_instr_o, wr_addr_o, wr_data_o}, exp);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0; wr_ready_i = 1'b0; halt_i = 1'b0; bar_commit_i = 1'b0; bar_val_i = '0;
    quiet();
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_wr_valid", wr_valid_o, 0);
    chk("rst_pc_valid", pc_wr_valid_o, 0);
    chk("rst_barrier", barrier_o, 0);
    chk("rst_exc", exception_o, 0);
    reset = 1'b1;

    // Two writes, head held, then drained in order
    send(OpInstr, 10'd1, 10'd5, 32'hA);
    chk("ready_instr", net_ready_o, 1);
    q.push_back({1'b1, 10'd5, 32'hA});
    tick();
    chk("latency_count", fifo_count_o, 1);
    chk("latency_valid", wr_valid_o, 1);
    send(OpReg, 10'd1, 10'd3, 32'h7);
    q.push_back({1'b0, 10'd3, 32'h7});
    tick();
    quiet();
    chk("two_count", fifo_count_o, 2);
    chk("two_head", {wr_is_instr_o, wr_addr_o, wr_data_o}, q[0]);
    wr_ready_i = 1'b1; #1;
    consume("pop0"); tick();
    consume("pop1"); tick();
    wr_ready_i = 1'b0; #1;
    chk("drained_count", fifo_count_o, 0);
    chk("drained_valid", wr_valid_o, 0);

    // Fill to DEPTH, full backpressure, then simultaneous push+pop
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      send((i % 2 == 0) ? OpInstr : OpReg, 10'd1, 10'(10 + i), d);
      q.push_back({(i % 2 == 0), 10'(10 + i), d});
      tick();
    end
    quiet();
    chk("full_count", fifo_count_o, 4);
    send(OpInstr, 10'd1, 10'h1F, 32'hDEAD);
    chk("ready_full", net_ready_o, 0);
    tick();
    quiet();
    chk("full_hold", fifo_count_o, 4);
    wr_ready_i = 1'b1; #1;
    consume("pop_full"); tick();
    wr_ready_i = 1'b0; #1;
    chk("three_count", fifo_count_o, 3);
    send(OpReg, 10'd1, 10'h2A, 32'h1234);
    wr_ready_i = 1'b1; #1;
    chk("ready_pushpop", net_ready_o, 1);
    consume("pushpop");
    q.push_back({1'b0, 10'h2A, 32'h1234});
    tick();
    quiet();
    wr_ready_i = 1'b0; #1;
    chk("pushpop_count", fifo_count_o, 3);

    // BAR mask, PC blocked while queue busy, then accepted
    send(OpBar, 10'd1, 10'd0, 32'b101);
    tick();
    quiet();
    chk("bar_idle", barrier_o, 0);
    send(OpPc, 10'd1, 10'h10, 32'h7);
    chk("ready_pc_busy", net_ready_o, 0);
    tick();
    quiet();
    chk("pc_busy_state", state_o, 0);
    chk("pc_busy_pulse", pc_wr_valid_o, 0);
    wr_ready_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      consume("drain"); tick();
    end
    wr_ready_i = 1'b0; #1;
    chk("pre_pc_count", fifo_count_o, 0);
    send(OpPc, 10'd1, 10'h10, 32'h7);
    chk("ready_pc", net_ready_o, 1);
    tick();
    quiet();
    chk("pc_pulse", pc_wr_valid_o, 1);
    chk("pc_addr", pc_wr_addr_o, 10'h10);
    chk("run_state", state_o, 1);
    chk("bar_after_pc", barrier_o, 3'b101);
    tick();
    chk("pc_pulse_one", pc_wr_valid_o, 0);

    // Barrier commit in RUN, halt, commit ignored in IDLE
    bar_commit_i = 1'b1; bar_val_i = 3'b001;
    tick();
    bar_commit_i = 1'b0;
    chk("bar_commit", barrier_o, 3'b001);
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    chk("halt_idle", state_o, 0);
    bar_commit_i = 1'b1; bar_val_i = 3'b111;
    tick();
    bar_commit_i = 1'b0;
    chk("bar_commit_idle", barrier_o, 3'b001);

    // Second PC while running -> ERR
    send(OpPc, 10'd1, 10'h20, 32'h6);
    tick();
    quiet();
    chk("run2_state", state_o, 1);
    chk("run2_barrier", barrier_o, 3'b100);
    send(OpInstr, 10'd1, 10'd7, 32'h55);
    tick();
    quiet();
    chk("run2_count", fifo_count_o, 1);
    send(OpPc, 10'd1, 10'h30, 32'h0);
    tick();
    quiet();
    q.delete();
    chk("err_state", state_o, 2);
    chk("err_exc", exception_o, 1);
    chk("err_flush", fifo_count_o, 0);
    chk("err_wr_valid", wr_valid_o, 0);
    chk("err_no_pulse", pc_wr_valid_o, 0);
    send(OpBar, 10'd1, 10'd0, 32'b010);
    tick();
    quiet();
    chk("err_bar", barrier_o, 3'b100);
    send(OpInstr, 10'd1, 10'd1, 32'h1);
    chk("ready_err", net_ready_o, 1);
    tick();
    quiet();
    chk("err_no_push", fifo_count_o, 0);
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    chk("err_sticky", state_o, 2);
    chk("err_exc_sticky", exception_o, 1);

    // Reset recovery, broadcast, non-matching, reset mid-fill
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_state", state_o, 0);
    chk("rst2_exc", exception_o, 0);
    chk("rst2_barrier", barrier_o, 0);
    send(OpInstr, 10'h3FF, 10'd9, 32'h99);
    q.push_back({1'b1, 10'd9, 32'h99});
    tick();
    quiet();
    chk("bcast_count", fifo_count_o, 1);
    chk("bcast_off_count", b_fifo_count_o, 0);
    chk("bcast_head", {wr_is_instr_o, wr_addr_o, wr_data_o}, q[0]);
    send(OpInstr, 10'd5, 10'd1, 32'h1);
    chk("ready_nomatch", net_ready_o, 1);
    tick();
    quiet();
    chk("nomatch_count", fifo_count_o, 1);
    for (int i = 0; i < 2; i++) begin
      send(OpReg, 10'd1, 10'(20 + i), 32'(i));
      tick();
    end
    quiet();
    chk("prerst_count", fifo_count_o, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    q.delete();
    chk("midrst_count", fifo_count_o, 0);
    chk("midrst_valid", wr_valid_o, 0);
    send(OpPc, 10'd1, 10'h40, 32'h0);
    reset = 1'b0;
    tick();
    quiet();
    reset = 1'b1;
    chk("rst_pc_pulse", pc_wr_valid_o, 0);
    chk("rst_pc_state", state_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/net_cmd_unit.md
NET_CMD_UNIT -- requirements
Module: net_cmd_unit

Interface
REQ-001 Parameter ID_W, default 10, width of the network core ID.
REQ-002 Parameter NET_ID, default 10'b0000000001, this core's ID.
REQ-003 Parameter BCAST_EN, default 1, when 1 ID all-ones is also accepted as a match.
REQ-004 Parameters ADDR_W 10, DATA_W 32, MASK_W 3, DEPTH 4 (power of 2, >=2): address, data, barrier and FIFO sizes.
REQ-005 Clock and reset SHALL be: reset reset, synchronous, active-low; clock clk.
REQ-006 Port list (name direction width meaning):
  clk in 1 clock; reset in 1 sync active-low reset
  net_valid_i in 1 packet present; net_id_i in ID_W destination ID
  net_op_i in 3 opcode: 0 NULL, 1 INSTR, 2 REG, 3 PC, 4 BAR, others NULL
  net_addr_i in ADDR_W target address; net_data_i in DATA_W payload
  net_ready_o out 1 packet accepted this cycle when high with net_valid_i
  wr_valid_o out 1 queued write at FIFO head; wr_is_instr_o out 1 1=imem, 0=reg file
  wr_addr_o out ADDR_W head address; wr_data_o out DATA_W head data
  wr_ready_i in 1 core consumes head this cycle
  pc_wr_valid_o out 1 one-cycle start pulse; pc_wr_addr_o out ADDR_W start PC
  halt_i in 1 core finished, return to IDLE
  bar_commit_i in 1 BAR instruction committing; bar_val_i in MASK_W its value
  barrier_o out MASK_W masked barrier; state_o out 2 IDLE=0 RUN=1 ERR=2
  exception_o out 1 sticky error; fifo_count_o out $clog2(DEPTH)+1 occupancy

Function
REQ-007 Match = net_valid_i & (net_id_i==NET_ID | (BCAST_EN & net_id_i all-ones)); non-matching packets ignored, net_ready_o=1.
REQ-008 net_ready_o: INSTR/REG -> FIFO not full; PC -> FIFO empty; BAR/NULL -> 1; state ERR -> 1 for all ops.
REQ-009 Accepted INSTR/REG (match & ready, state!=ERR) pushed with {op==INSTR, addr, data}; visible on wr_* next cycle (1-cycle latency).
REQ-010 FIFO show-ahead: wr_valid_o = !empty & state!=ERR; pop on wr_valid_o & wr_ready_i; order strictly preserved.
REQ-011 Push and pop in same cycle SHALL both occur; count unchanged; pointers wrap modulo DEPTH.
REQ-012 Matching INSTR/REG with FIFO full: not accepted, no state change; upstream holds.
REQ-013 Accepted PC in IDLE: next cycle pc_wr_valid_o=1 for exactly one cycle, pc_wr_addr_o=net_addr_i, barrier value loaded from net_data_i[MASK_W-1:0], state->RUN.
REQ-014 PC packet matching while state==RUN: state->ERR next cycle, no pc_wr pulse.
REQ-015 RUN->IDLE on halt_i; halt_i in IDLE/ERR ignored.
REQ-016 ERR is terminal until reset; on entry FIFO flushed (count 0), wr_valid_o held 0.
REQ-017 exception_o asserted the cycle state_o becomes ERR, stays 1 until reset.
REQ-018 BAR packet loads barrier mask from net_data_i[MASK_W-1:0] unless state==ERR.
REQ-019 bar_commit_i in RUN loads barrier value from bar_val_i; ignored in IDLE/ERR.
REQ-020 barrier_o = mask_r & value_r, both registers (no combinational path from inputs).
REQ-021 fifo_count_o reflects registered occupancy, 0..DEPTH.

Reset
REQ-022 On reset low at clk edge: state IDLE, FIFO empty, mask and value 0, exception_o 0, pc_wr_valid_o 0, wr_valid_o 0, barrier_o 0, fifo_count_o 0.
REQ-023 Reset mid-operation discards FIFO contents and any pending pc_wr pulse.

Verification
REQ-024 Push INSTR addr 5 data 0xA, REG addr 3 data 0x7, wr_ready_i=0 -> count 2, head {1,5,0xA}; wr_ready_i=1 two cycles -> {0,3,0x7} then empty.
REQ-025 Fill DEPTH=4 entries, present 5th INSTR -> net_ready_o=0, count 4; same-cycle push+pop at count 3 -> count 3.
REQ-026 FIFO non-empty, PC packet addr 0x10 -> net_ready_o=0; drain; PC accepted -> one-cycle pc_wr_valid_o, pc_wr_addr_o=0x10, state RUN.
REQ-027 In RUN send PC packet -> state ERR, exception_o=1, FIFO flushed, later BAR packet leaves mask unchanged.
REQ-028 BAR mask 3'b101, PC data 3'b111 -> barrier_o 3'b101; bar_commit_i bar_val_i 3'b001 -> barrier_o 3'b001; halt_i -> IDLE.
REQ-029 Packet with ID all-ones, BCAST_EN=1 accepted; BCAST_EN=0 ignored; reset asserted with count 3 -> count 0 next cycle.
